uart_caesar_encoder_core: RTL and testbench

UART_CAESAR_ENCODER_CORE -- requirements
Module: caesar_stream_encoder

---
 rtl/uart_caesar_encoder_core.sv | 205 ++++++++++++++++++++
 tb/tb_uart_caesar_encoder_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_caesar_encoder_core.sv
// ============================================================================
// Module   : uart_caesar_encoder_core
// Purpose  : Buffers one newline-terminated frame, applies a Caesar shift keyed
//            by the frame's first byte, and streams the result back out.
//            Optional macro CAESAR_DIGIT_ROT_EN also rotates digits mod 10.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_caesar_encoder_core #(
    parameter int MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       overflow
);

    localparam int c_cnt_w  = $clog2(MAX_LEN + 1);
    localparam int c_addr_w = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_max_len = c_cnt_w'(MAX_LEN);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);
    localparam logic [7:0] c_lf   = 8'h0A;
    localparam logic [7:0] c_bang = 8'h21;

    typedef enum logic [1:0] {
        S_WAIT_KEY = 2'd0,
        S_LOAD     = 2'd1,
        S_ENCODE   = 2'd2,
        S_SEND     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         key_q, key_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic [c_cnt_w-1:0] idx_q, idx_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               overflow_q, overflow_d;
    logic               rdy_en_q;

    logic [7:0]          mem_q [MAX_LEN];
    logic                buf_we;
    logic [c_addr_w-1:0] buf_waddr;
    logic [7:0]          buf_wdata;

    logic               w_accept;
    logic [4:0]         w_key_in;
    logic [c_cnt_w-1:0] w_idx_nxt;
    logic [7:0]         w_rd_idx;
    logic [7:0]         w_rd_first;
    logic [7:0]         w_rd_next;
    logic               w_last;
    logic [7:0]         w_byte_next;

    // Letters use a single conditional subtract: (c-base)+key never exceeds 50.
    function automatic logic [7:0] caesar(input logic [7:0] c, input logic [4:0] k);
        logic [5:0] sum;
        logic [7:0] res;
        res = c;
        sum = '0;
        if (c >= 8'h41 && c <= 8'h5A) begin
            sum = 6'(c - 8'h41) + 6'(k);
            if (sum >= 6'd26) sum = sum - 6'd26;
            res = 8'h41 + 8'(sum);
        end else if (c >= 8'h61 && c <= 8'h7A) begin
            sum = 6'(c - 8'h61) + 6'(k);
            if (sum >= 6'd26) sum = sum - 6'd26;
            res = 8'h61 + 8'(sum);
        end
`ifdef CAESAR_DIGIT_ROT_EN
        else if (c >= 8'h30 && c <= 8'h39) begin
            sum = 6'(c - 8'h30) + 6'(k % 5'd10);
            if (sum >= 6'd10) sum = sum - 6'd10;
            res = 8'h30 + 8'(sum);
        end
`endif
        return res;
    endfunction

    assign in_ready  = rdy_en_q && ((state_q == S_WAIT_KEY) || (state_q == S_LOAD));
    assign busy      = (state_q != S_WAIT_KEY);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overflow  = overflow_q;

    assign w_accept  = in_valid && in_ready;
    assign w_key_in  = (in_data >= 8'h30 && in_data <= 8'h39) ? 5'(in_data - 8'h30)
                                                               : 5'(in_data % 8'd26);
    assign w_idx_nxt  = idx_q + c_one;
    assign w_rd_idx   = mem_q[idx_q[c_addr_w-1:0]];
    assign w_rd_first = mem_q[0];
    assign w_rd_next  = mem_q[w_idx_nxt[c_addr_w-1:0]];

    // During an overflowed frame the send sequence is just "!" then LF.
    assign w_last      = overflow_q ? (idx_q == c_one) : (idx_q == count_q);
    assign w_byte_next = overflow_q ? c_lf : ((w_idx_nxt < count_q) ? w_rd_next : c_lf);

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        count_d     = count_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        overflow_d  = overflow_q;
        buf_we      = 1'b0;
        buf_waddr   = count_q[c_addr_w-1:0];
        buf_wdata   = in_data;

        case (state_q)
            S_WAIT_KEY: begin
                if (w_accept) begin
                    key_d      = w_key_in;
                    count_d    = '0;
                    idx_d      = '0;
                    overflow_d = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    if (in_data == c_lf) begin
                        idx_d   = '0;
                        state_d = S_ENCODE;
                    end else if (count_q < c_max_len) begin
                        buf_we  = 1'b1;
                        count_d = count_q + c_one;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            S_ENCODE: begin
                if (overflow_q) begin
                    idx_d   = '0;
                    state_d = S_SEND;
                end else if (idx_q < count_q) begin
                    buf_we    = 1'b1;
                    buf_waddr = idx_q[c_addr_w-1:0];
                    buf_wdata = caesar(w_rd_idx, key_q);
                    idx_d     = w_idx_nxt;
                end else begin
                    // Present the first byte on the same edge we enter S_SEND.
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = (count_q == '0) ? c_lf : w_rd_first;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = overflow_q ? c_bang : c_lf;
                end else if (out_ready) begin
                    if (w_last) begin
                        out_valid_d = 1'b0;
                        idx_d       = '0;
                        state_d     = S_WAIT_KEY;
                    end else begin
                        idx_d      = w_idx_nxt;
                        out_data_d = w_byte_next;
                    end
                end
            end
            default: state_d = S_WAIT_KEY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT_KEY;
            key_q       <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
            rdy_en_q    <= 1'b1;
        end
    end

    // Message storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (buf_we) mem_q[buf_waddr] <= buf_wdata;
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_caesar_encoder_core.sv
// ============================================================================
// Module   : tb_uart_caesar_encoder_core
// Purpose  : Directed and randomized frames checked against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_caesar_encoder_core;

    localparam int MAX_LEN = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       overflow;

    int n_checks = 0;
    int n_err    = 0;

    byte unsigned msg[$];
    byte unsigned exp_q[$];
    byte unsigned got[$];

    uart_caesar_encoder_core #(.MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_key(input byte unsigned b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        return int'(b) % 26;
    endfunction

    function automatic byte unsigned ref_enc(input byte unsigned c, input int k);
        if (c >= 8'h41 && c <= 8'h5A) return byte'(65 + (int'(c) - 65 + k) % 26);
        if (c >= 8'h61 && c <= 8'h7A) return byte'(97 + (int'(c) - 97 + k) % 26);
`ifdef CAESAR_DIGIT_ROT_EN
        if (c >= 8'h30 && c <= 8'h39) return byte'(48 + (int'(c) - 48 + k) % 10);
`endif
        return c;
    endfunction

    task automatic set_msg(input string s);
        msg.delete();
        for (int i = 0; i < s.len(); i++) msg.push_back(byte'(s[i]));
    endtask

    task automatic send_byte(input byte unsigned b);
        int n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic recv_frame(input string tag, input int stall_pct);
        logic [7:0] prev_d = 8'h00;
        bit prev_stall = 1'b0;
        bit done = 1'b0;
        int budget = 0;
        got.delete();
        while (!done && budget < 5000) begin
            @(negedge clk);
            if (prev_stall) begin
                check({tag, ":stall_valid"}, 32'(out_valid), 32'd1);
                check({tag, ":stall_data"}, 32'(out_data), 32'(prev_d));
            end
            out_ready  = ($urandom_range(99) >= stall_pct);
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                if (out_data == 8'h0A) done = 1'b1;
            end
            budget++;
        end
        if (!done) check({tag, ":recv_timeout"}, 32'(done), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_frame(input string tag, input byte unsigned key_b, input int stall_pct);
        int lat;
        int k;
        bit ovf;
        k   = ref_key(key_b);
        ovf = (msg.size() > MAX_LEN);
        exp_q.delete();
        if (ovf) exp_q.push_back(8'h21);
        else foreach (msg[i]) exp_q.push_back(ref_enc(msg[i], k));
        exp_q.push_back(8'h0A);

        send_byte(key_b);
        foreach (msg[i]) send_byte(msg[i]);
        send_byte(8'h0A);

        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ":latency"}, 32'(lat), ovf ? 32'd2 : 32'(msg.size() + 1));
        check({tag, ":overflow"}, 32'(overflow), 32'(ovf));
        check({tag, ":busy_send"}, 32'(busy), 32'd1);

        recv_frame(tag, stall_pct);
        check({tag, ":len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s:byte%0d", tag, i),
                  (i < got.size()) ? 32'(got[i]) : 32'h1FF, 32'(exp_q[i]));
        check({tag, ":valid_after"}, 32'(out_valid), 32'd0);
        check({tag, ":busy_after"}, 32'(busy), 32'd0);
        check({tag, ":ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int len;
        byte unsigned b;

        // Reset state
        #25;
        check("rst:out_valid", 32'(out_valid), 32'd0);
        check("rst:out_data", 32'(out_data), 32'd0);
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:overflow", 32'(overflow), 32'd0);
        check("rst:in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst:in_ready_release", 32'(in_ready), 32'd1);

        set_msg("Hello, xyz");
        run_frame("hello", 8'h33, 0);

        set_msg("Z");
        run_frame("rawkey", 8'h1D, 0);

        msg.delete();
        for (int i = 0; i < 65; i++) msg.push_back(8'h61);
        run_frame("ovf65", 8'h31, 0);

        msg.delete();
        for (int i = 0; i < MAX_LEN; i++) msg.push_back(8'h7A);
        run_frame("full64", 8'h31, 0);

        msg.delete();
        run_frame("empty", 8'h35, 0);

        set_msg("Stall 0-9!");
        run_frame("stall10", 8'h37, 50);

        // Reset while a frame is stuck in S_SEND
        set_msg("abcdef");
        send_byte(8'h34);
        foreach (msg[i]) send_byte(msg[i]);
        send_byte(8'h0A);
        repeat (12) @(posedge clk);
        #1;
        check("midrst:held_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst:out_valid", 32'(out_valid), 32'd0);
        check("midrst:busy", 32'(busy), 32'd0);
        check("midrst:out_data", 32'(out_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst:in_ready", 32'(in_ready), 32'd1);
        set_msg("ab");
        run_frame("after_rst", 8'h32, 0);

        // Randomized frames
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(0, 70);
            msg.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(3) != 0) b = byte'($urandom_range(8'h20, 8'h7E));
                else b = byte'($urandom_range(0, 255));
                if (b == 8'h0A) b = 8'h0B;
                msg.push_back(b);
            end
            run_frame($sformatf("rand%0d", r), byte'($urandom_range(0, 255)),
                      int'($urandom_range(0, 60)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
